pipeline_stall_controller: RTL and testbench

//  Hazard/stall sequencer for the 5-stage pipeline; companion to the EXE-stage forwarding unit.

---
 rtl/pipeline_stall_controller_pkg.sv | 32 +++
 rtl/pipeline_stall_controller_hazard.sv | 35 +++
 rtl/pipeline_stall_controller.sv | 152 +++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_stall_controller_pkg
//  Purpose  : Shared widths, FSM state codes and register-compare helper for
//             the pipeline stall controller and its hazard-detect unit.
//  Revision : 1.0 - initial release
// ============================================================================
package pipeline_stall_controller_pkg;

  // Register-file address width used by the ID/EXE/MEM operand fields
  localparam int REG_LENGTH       = 5;
  // Default width of the saturating stall-cycle counter
  localparam int STALL_CNT_LENGTH = 16;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_e;

  // RAW hit: a writing stage targets source 1, or source 2 when it is a real operand
  function automatic logic raw_hit(
    input logic                  wb_en,
    input logic [REG_LENGTH-1:0] dest,
    input logic [REG_LENGTH-1:0] src1,
    input logic [REG_LENGTH-1:0] src2,
    input logic                  two_src
  );
    return wb_en & ((src1 == dest) | (two_src & (src2 == dest)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_stall_controller_hazard.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_stall_controller_hazard
//  Purpose  : Hazard-detect unit. Purely combinational RAW check at ID against
//             the EXE and MEM destinations; only load-use stalls while the
//             forwarding unit is active.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller_hazard
  import pipeline_stall_controller_pkg::*;
(
  input  logic                  forward_en_i,
  input  logic [REG_LENGTH-1:0] src1_i,
  input  logic [REG_LENGTH-1:0] src2_i,
  input  logic                  two_src_i,
  input  logic [REG_LENGTH-1:0] dest_exe_i,
  input  logic                  wb_en_exe_i,
  input  logic                  mem_r_en_exe_i,
  input  logic [REG_LENGTH-1:0] dest_mem_i,
  input  logic                  wb_en_mem_i,
  output logic                  stall_o
);

  logic hz_exe;
  logic hz_mem;

  // With forwarding, only an EXE load cannot be bypassed in time
  always_comb begin
    hz_exe  = raw_hit(wb_en_exe_i, dest_exe_i, src1_i, src2_i, two_src_i);
    hz_mem  = raw_hit(wb_en_mem_i, dest_mem_i, src1_i, src2_i, two_src_i);
    stall_o = forward_en_i ? (hz_exe & mem_r_en_exe_i) : (hz_exe | hz_mem);
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_stall_controller
//  Purpose  : Hazard/stall sequencer for the 5-stage pipeline. Combines ID
//             RAW stalls, SRAM wait-state freezes and branch flushes into
//             freeze/bubble/flush controls; tracks SRAM timeout and stall time.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int STALL_CNT_W = STALL_CNT_LENGTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   forward_en,
  input  logic [REG_LENGTH-1:0]  src1_ID,
  input  logic [REG_LENGTH-1:0]  src2_ID,
  input  logic                   two_src_ID,
  input  logic [REG_LENGTH-1:0]  dest_EXE,
  input  logic                   WB_EN_EXE,
  input  logic                   MEM_R_EN_EXE,
  input  logic [REG_LENGTH-1:0]  dest_MEM,
  input  logic                   WB_EN_MEM,
  input  logic                   branch_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   freeze_IF,
  output logic                   freeze_pipe,
  output logic                   bubble_EXE,
  output logic                   flush_IF,
  output logic                   mem_error,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_e              state_q, state_d;
  logic [WCNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                   pending_flush_q, pending_flush_d;
  logic                   mem_error_q, mem_error_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic stall;
  logic wait_start;
  logic freeze_if_c, freeze_pipe_c, bubble_c, flush_c;

  pipeline_stall_controller_hazard u_hazard (
    .forward_en_i   (forward_en),
    .src1_i         (src1_ID),
    .src2_i         (src2_ID),
    .two_src_i      (two_src_ID),
    .dest_exe_i     (dest_EXE),
    .wb_en_exe_i    (WB_EN_EXE),
    .mem_r_en_exe_i (MEM_R_EN_EXE),
    .dest_mem_i     (dest_MEM),
    .wb_en_mem_i    (WB_EN_MEM),
    .stall_o        (stall)
  );

  assign wait_start = mem_req & ~mem_ready;

  // Next-state and same-cycle control decode; a taken branch overrides a RAW stall
  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    pending_flush_d = pending_flush_q;
    mem_error_d     = mem_error_q;
    freeze_if_c     = 1'b0;
    freeze_pipe_c   = 1'b0;
    bubble_c        = 1'b0;
    flush_c         = 1'b0;
    case (state_q)
      HZ_RUN: begin
        if (wait_start) begin
          freeze_if_c     = 1'b1;
          freeze_pipe_c   = 1'b1;
          state_d         = HZ_MEM_WAIT;
          wait_cnt_d      = WCNT_W'(1);
          // a flush still owed from a timed-out wait must not be lost
          pending_flush_d = pending_flush_q | branch_taken;
        end else if (pending_flush_q) begin
          // first free cycle after a timeout delivers the deferred flush
          flush_c         = 1'b1;
          bubble_c        = 1'b1;
          pending_flush_d = 1'b0;
        end else begin
          flush_c     = branch_taken;
          bubble_c    = branch_taken | stall;
          freeze_if_c = stall & ~branch_taken;
        end
      end
      HZ_MEM_WAIT: begin
        if (!mem_ready) begin
          freeze_if_c     = 1'b1;
          freeze_pipe_c   = 1'b1;
          pending_flush_d = pending_flush_q | branch_taken;
          if (wait_cnt_q == WCNT_W'(MEM_TIMEOUT)) begin
            mem_error_d = 1'b1;
            state_d     = HZ_RUN;
          end else begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
          end
        end else begin
          state_d         = HZ_RUN;
          pending_flush_d = 1'b0;
          if (pending_flush_q | branch_taken) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
          end else begin
            bubble_c    = stall;
            freeze_if_c = stall;
          end
        end
      end
      default: state_d = HZ_RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    if ((freeze_if_c | freeze_pipe_c) && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // State, counters and sticky flag; reset abandons any in-flight wait
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= HZ_RUN;
      wait_cnt_q      <= '0;
      pending_flush_q <= 1'b0;
      mem_error_q     <= 1'b0;
      stall_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      pending_flush_q <= pending_flush_d;
      mem_error_q     <= mem_error_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  // Pipeline controls are held inactive while reset is asserted
  assign freeze_IF   = rst & freeze_if_c;
  assign freeze_pipe = rst & freeze_pipe_c;
  assign bubble_EXE  = rst & bubble_c;
  assign flush_IF    = rst & flush_c;
  assign mem_error   = mem_error_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_stall_controller
//  Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//             compared against a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_controller;
  import pipeline_stall_controller_pkg::*;

  localparam int TO   = 8;
  localparam int SW   = 8;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, forward_en, two_src_ID, WB_EN_EXE, MEM_R_EN_EXE, WB_EN_MEM;
  logic branch_taken, mem_req, mem_ready;
  logic [REG_LENGTH-1:0] src1_ID, src2_ID, dest_EXE, dest_MEM;
  logic freeze_IF, freeze_pipe, bubble_EXE, flush_IF, mem_error;
  logic [SW-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: "in a wait", cycles spent waiting, owed flush, error, freeze total
  bit m_waiting, m_owed, m_err;
  int m_waited, m_frozen;
  bit e_fi, e_fp, e_bub, e_fl;

  pipeline_stall_controller #(.MEM_TIMEOUT(TO), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en),
    .src1_ID(src1_ID), .src2_ID(src2_ID), .two_src_ID(two_src_ID),
    .dest_EXE(dest_EXE), .WB_EN_EXE(WB_EN_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE),
    .dest_MEM(dest_MEM), .WB_EN_MEM(WB_EN_MEM), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_IF(freeze_IF), .freeze_pipe(freeze_pipe), .bubble_EXE(bubble_EXE),
    .flush_IF(flush_IF), .mem_error(mem_error), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit needs_stall();
    bit src_hits_exe, src_hits_mem;
    src_hits_exe = WB_EN_EXE && (src1_ID == dest_EXE || (two_src_ID && src2_ID == dest_EXE));
    src_hits_mem = WB_EN_MEM && (src1_ID == dest_MEM || (two_src_ID && src2_ID == dest_MEM));
    if (forward_en) return src_hits_exe && MEM_R_EN_EXE;
    return src_hits_exe || src_hits_mem;
  endfunction

  task automatic model_outputs();
    bit s;
    {e_fi, e_fp, e_bub, e_fl} = 4'b0000;
    s = needs_stall();
    if (rst) begin
      if ((mem_req && !mem_ready && !m_waiting) || (m_waiting && !mem_ready)) begin
        e_fi = 1; e_fp = 1;                       // SRAM is holding everything
      end else if (m_owed || (m_waiting && branch_taken) || branch_taken) begin
        e_fl = 1; e_bub = 1;                      // flush wins over any stall
      end else begin
        e_bub = s; e_fi = s;
      end
    end
  endtask

  task automatic model_advance();
    if (!rst) begin
      m_waiting = 0; m_owed = 0; m_err = 0; m_waited = 0; m_frozen = 0;
      return;
    end
    if (e_fi || e_fp) m_frozen = (m_frozen < SMAX) ? m_frozen + 1 : SMAX;
    if (!m_waiting) begin
      if (mem_req && !mem_ready) begin
        m_waiting = 1; m_waited = 1; m_owed = m_owed || branch_taken;
      end else begin
        m_owed = 0;
      end
    end else if (mem_ready) begin
      m_waiting = 0; m_owed = 0;
    end else begin
      m_owed = m_owed || branch_taken;
      if (m_waited >= TO) begin
        m_err = 1; m_waiting = 0;
      end else begin
        m_waited++;
      end
    end
  endtask

  // One clock: compare all outputs mid-cycle, then advance the model at the edge
  task automatic cycle();
    @(negedge clk);
    model_outputs();
    check("freeze_IF", freeze_IF, e_fi);
    check("freeze_pipe", freeze_pipe, e_fp);
    check("bubble_EXE", bubble_EXE, e_bub);
    check("flush_IF", flush_IF, e_fl);
    check("mem_error", mem_error, m_err);
    check("stall_cnt", stall_cnt, m_frozen);
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic idle();
    forward_en = 1; two_src_ID = 0; WB_EN_EXE = 0; MEM_R_EN_EXE = 0; WB_EN_MEM = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
    src1_ID = '0; src2_ID = '0; dest_EXE = '0; dest_MEM = '0;
  endtask

  task automatic do_reset();
    rst = 0; cycle(); cycle(); rst = 1;
  endtask

  initial begin
    idle();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    m_waiting = 0; m_owed = 0; m_err = 0; m_waited = 0; m_frozen = 0;
    cycle();
    rst = 1;
    check("reset_stall_cnt", stall_cnt, 0);
    check("reset_mem_error", mem_error, 0);

    // load-use stall with forwarding
    dest_EXE = 3; WB_EN_EXE = 1; MEM_R_EN_EXE = 1; src1_ID = 3;
    #1; check("t1_freeze_IF", freeze_IF, 1); check("t1_bubble", bubble_EXE, 1);
    cycle();
    idle();
    check("t1_stall_cnt", stall_cnt, 1);
    #1; check("t1_released", freeze_IF, 0);
    cycle();

    // non-load with forwarding, then forwarding off, then MEM RAW on src2
    dest_EXE = 3; WB_EN_EXE = 1; MEM_R_EN_EXE = 0; src1_ID = 3;
    #1; check("t2_fwd_no_stall", freeze_IF, 0);
    cycle();
    forward_en = 0;
    #1; check("t2_nofwd_stall", freeze_IF, 1);
    cycle();
    WB_EN_EXE = 0; src1_ID = 0; dest_MEM = 5; WB_EN_MEM = 1; src2_ID = 5; two_src_ID = 1;
    #1; check("t2_mem_src2_stall", freeze_IF, 1);
    cycle();
    two_src_ID = 0;
    #1; check("t2_mem_src2_ignored", freeze_IF, 0);
    cycle();

    // 4-cycle SRAM wait then release
    idle(); do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1; check("t3_freeze_pipe", freeze_pipe, 1);
      cycle();
    end
    mem_ready = 1;
    #1; check("t3_release", freeze_pipe, 0);
    cycle();
    idle();
    check("t3_stall_cnt", stall_cnt, 4);
    #1; check("t3_back_in_run", freeze_pipe, 0);
    cycle();
    mem_req = 1; mem_ready = 1;
    #1; check("t3_single_cycle", freeze_pipe, 0);
    cycle();

    // branch during wait-start is deferred to the release cycle
    idle();
    mem_req = 1; branch_taken = 1;
    #1; check("t4_no_flush_start", flush_IF, 0); check("t4_no_bubble_start", bubble_EXE, 0);
    cycle();
    branch_taken = 0;
    for (int i = 0; i < 2; i++) begin
      #1; check("t4_no_flush_wait", flush_IF, 0);
      cycle();
    end
    mem_ready = 1;
    #1; check("t4_flush_release", flush_IF, 1); check("t4_bubble_release", bubble_EXE, 1);
    check("t4_no_freeze_release", freeze_IF, 0);
    cycle();
    idle();
    #1; check("t4_flush_once", flush_IF, 0);
    cycle();

    // SRAM timeout
    mem_req = 1;
    repeat (TO) cycle();
    check("t5_no_error_yet", mem_error, 0);
    cycle();
    check("t5_error_set", mem_error, 1);
    mem_req = 0;
    #1; check("t5_in_run", freeze_pipe, 0);
    repeat (3) cycle();
    check("t5_error_sticky", mem_error, 1);

    // reset in the middle of a wait with a flush owed
    do_reset();
    mem_req = 1; branch_taken = 1;
    cycle();
    branch_taken = 0;
    cycle();
    rst = 0; branch_taken = 1;
    #1; check("t6_rst_outputs", {freeze_IF, freeze_pipe, bubble_EXE, flush_IF}, 0);
    cycle(); cycle();
    rst = 1; idle();
    #1; check("t6_no_flush", flush_IF, 0); check("t6_run", freeze_pipe, 0);
    check("t6_stall_cnt", stall_cnt, 0); check("t6_mem_error", mem_error, 0);
    cycle();

    // saturation of the stall counter through repeated timeouts
    mem_req = 1;
    repeat (SMAX + 40) cycle();
    check("sat_stall_cnt", stall_cnt, SMAX);
    idle(); do_reset();

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst          = ($urandom_range(59, 0) != 0);
      forward_en   = $urandom_range(1, 0);
      two_src_ID   = $urandom_range(1, 0);
      WB_EN_EXE    = $urandom_range(1, 0);
      MEM_R_EN_EXE = $urandom_range(1, 0);
      WB_EN_MEM    = $urandom_range(1, 0);
      src1_ID      = REG_LENGTH'($urandom_range(3, 0));
      src2_ID      = REG_LENGTH'($urandom_range(3, 0));
      dest_EXE     = REG_LENGTH'($urandom_range(3, 0));
      dest_MEM     = REG_LENGTH'($urandom_range(3, 0));
      branch_taken = ($urandom_range(4, 0) == 0);
      mem_req      = ($urandom_range(2, 0) == 0);
      mem_ready    = ($urandom_range(i % 3 == 0 ? 12 : 2, 0) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
